// File: rtl/register_file_1r_1w_clr.sv
// Multi-row register file: one registered read port, one byte-enabled write port,
// optional write-first bypass and a hardware clear sequencer that zeroes all rows.
module register_file_1r_1w_clr #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 16,
  parameter int ADDR_WIDTH = $clog2(NUM_WORDS),
  parameter bit BYPASS     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ReadEnable,
  input  logic [ADDR_WIDTH-1:0]   ReadAddr,
  output logic [DATA_WIDTH-1:0]   ReadData,
  output logic                    ReadValid,
  input  logic                    WriteEnable,
  input  logic [ADDR_WIDTH-1:0]   WriteAddr,
  input  logic [DATA_WIDTH-1:0]   WriteData,
  input  logic [DATA_WIDTH/8-1:0] WriteBE,
  input  logic                    ClearReq,
  output logic                    Busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   NUM_WORDS_W = (ADDR_WIDTH + 1)'(NUM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST_CNT    = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  // Replace the enabled bytes of old_word with those of new_word.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NUM_BYTES-1:0]  be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
  logic                    read_valid_q, read_valid_d;
  logic [DATA_WIDTH-1:0]   mem_q [NUM_WORDS];

  logic                    busy_s;
  logic                    wr_accept_s;
  logic                    rd_accept_s;
  logic                    rd_in_range_s;
  logic [DATA_WIDTH-1:0]   rd_row_s;
  logic                    mem_we_s;
  logic [ADDR_WIDTH-1:0]   mem_addr_s;
  logic [DATA_WIDTH-1:0]   mem_wdata_s;
  logic [NUM_BYTES-1:0]    mem_be_s;

  assign busy_s        = (state_q == CLEAR);
  assign wr_accept_s   = WriteEnable & ~busy_s & ({1'b0, WriteAddr} < NUM_WORDS_W);
  assign rd_accept_s   = ReadEnable & ~busy_s;
  assign rd_in_range_s = ({1'b0, ReadAddr} < NUM_WORDS_W);

  // Clear sequencer next-state and row counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          cnt_d   = {ADDR_WIDTH{1'b0}};
        end else begin
          state_d = CLEAR;
          cnt_d   = cnt_q + ADDR_WIDTH'(1);
        end
      end
      IDLE: begin
        cnt_d = {ADDR_WIDTH{1'b0}};
        if (ClearReq) begin
          state_d = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  // Storage write port: clear rows while busy, otherwise the accepted user write.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = WriteAddr;
    mem_wdata_s = WriteData;
    mem_be_s    = WriteBE;
    if (busy_s) begin
      mem_we_s    = 1'b1;
      mem_addr_s  = cnt_q;
      mem_wdata_s = {DATA_WIDTH{1'b0}};
      mem_be_s    = {NUM_BYTES{1'b1}};
    end else begin
      mem_we_s = wr_accept_s;
    end
  end

  // Read path with optional same-address write-first forwarding.
  always_comb begin
    rd_row_s     = {DATA_WIDTH{1'b0}};
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    if (rd_in_range_s) begin
      rd_row_s = mem_q[ReadAddr];
    end else begin
      rd_row_s = {DATA_WIDTH{1'b0}};
    end
    if (BYPASS && wr_accept_s && (WriteAddr == ReadAddr)) begin
      rd_row_s = merge_bytes(rd_row_s, WriteData, WriteBE);
    end else begin
      rd_row_s = rd_row_s;
    end
    if (rd_accept_s) begin
      read_data_d  = rd_row_s;
      read_valid_d = 1'b1;
    end else begin
      read_data_d  = read_data_q;
      read_valid_d = 1'b0;
    end
  end

  // Control state; the array itself carries no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR;
      cnt_q        <= {ADDR_WIDTH{1'b0}};
      read_data_q  <= {DATA_WIDTH{1'b0}};
      read_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  // Byte-lane writes into the storage array.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (mem_be_s[b]) begin
          mem_q[mem_addr_s][8*b +: 8] <= mem_wdata_s[8*b +: 8];
        end
      end
    end
  end

  assign ReadData  = read_data_q;
  assign ReadValid = read_valid_q;
  assign Busy      = busy_s;

endmodule
